// File: rtl/up_exec_core.sv
// up_exec_core: executes ROM control words on a 4x8 register bank, accumulator A and carry flag CY.
// Optional single-step gating is enabled by defining UP_STEP_EN (adds the step input).
`timescale 1ns/1ps

`ifndef LD
`define LD  3'b000
`endif
`ifndef ADD
`define ADD 3'b001
`endif
`ifndef SUB
`define SUB 3'b010
`endif
`ifndef NOT
`define NOT 3'b011
`endif
`ifndef AND
`define AND 3'b100
`endif
`ifndef ST
`define ST  3'b101
`endif

module up_exec_core #(
   parameter logic [7:0] R0_INIT = 8'd0,
   parameter logic [7:0] R1_INIT = 8'd1,
   parameter logic [7:0] R2_INIT = 8'd2,
   parameter logic [7:0] R3_INIT = 8'd4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
`ifdef UP_STEP_EN
   input  logic       step,
`endif
   output logic [4:0] addr,
   input  logic [3:0] RegAddr,
   input  logic [2:0] ALUCode,
   input  logic       Reg_CE,
   input  logic       CY_CE,
   input  logic       A_CE,
   input  logic       ResetCY,
   output logic [7:0] acc,
   output logic       cy,
   output logic       busy,
   output logic       halted,
   output logic       err
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_HALT
   } state_t;

   state_t     state_q, state_d;
   logic [4:0] pc_q, pc_d;
   logic [7:0] a_q, a_d;
   logic       cy_q, cy_d;
   logic       err_q, err_d;
   logic [7:0] r_q [4];
   logic [7:0] r_d [4];

   logic [1:0] sel;
   logic       onehot;
   logic       halt_word;
   logic       illegal_word;
   logic       step_ok;
   logic       is_arith;
   logic [7:0] opnd;
   logic [8:0] sum9;
   logic [8:0] diff9;
   logic [7:0] alu_a;
   logic       alu_c;

`ifdef UP_STEP_EN
   assign step_ok = step;
`else
   assign step_ok = 1'b1;
`endif

   always_comb begin
      sel    = 2'd0;
      onehot = 1'b1;
      case (RegAddr)
         4'b0001: sel = 2'd0;
         4'b0010: sel = 2'd1;
         4'b0100: sel = 2'd2;
         4'b1000: sel = 2'd3;
         default: onehot = 1'b0;
      endcase
   end

   // A halt encoding takes precedence over the illegal-select check
   assign halt_word    = (ALUCode == 3'b111) || (RegAddr == 4'b1111);
   assign illegal_word = !onehot && !halt_word;
   assign is_arith     = (ALUCode == `ADD) || (ALUCode == `SUB);
   assign opnd         = r_q[sel];

   // Subtraction borrow appears in bit 8 of the 9-bit wrapped difference
   assign sum9  = {1'b0, a_q} + {1'b0, opnd} + {8'd0, cy_q};
   assign diff9 = {1'b0, a_q} - {1'b0, opnd} - {8'd0, cy_q};

   always_comb begin
      alu_a = a_q;
      alu_c = 1'b0;
      case (ALUCode)
         `LD:     alu_a = opnd;
         `ADD:    {alu_c, alu_a} = sum9;
         `SUB:    {alu_c, alu_a} = diff9;
         `NOT:    alu_a = ~a_q;
         `AND:    alu_a = a_q & opnd;
         default: alu_a = a_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      a_d     = a_q;
      cy_d    = cy_q;
      err_d   = err_q;
      r_d     = r_q;
      case (state_q)
         ST_RUN: begin
            if (step_ok) begin
               if (halt_word) begin
                  state_d = ST_HALT;
               end else if (illegal_word) begin
                  err_d   = 1'b1;
                  state_d = ST_HALT;
               end else begin
                  if (A_CE) a_d = alu_a;
                  if (ResetCY) cy_d = 1'b0;
                  else if (CY_CE && is_arith) cy_d = alu_c;
                  if (Reg_CE) r_d[sel] = a_q;
                  if (pc_q == 5'd31) state_d = ST_HALT;
                  else pc_d = pc_q + 5'd1;
               end
            end
         end
         default: begin
            if (start) begin
               pc_d    = '0;
               err_d   = 1'b0;
               state_d = ST_RUN;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         a_q     <= '0;
         cy_q    <= 1'b0;
         err_q   <= 1'b0;
         r_q[0]  <= R0_INIT;
         r_q[1]  <= R1_INIT;
         r_q[2]  <= R2_INIT;
         r_q[3]  <= R3_INIT;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         a_q     <= a_d;
         cy_q    <= cy_d;
         err_q   <= err_d;
         r_q     <= r_d;
      end
   end

   assign addr   = pc_q;
   assign acc    = a_q;
   assign cy     = cy_q;
   assign err    = err_q;
   assign busy   = (state_q == ST_RUN);
   assign halted = (state_q == ST_HALT);

endmodule
